// File: rtl/prbs_randomizer_par.sv
// -----------------------------------------------------------------------------
// prbs_randomizer_par
//
// Parallel PRBS data randomizer for the WiMax PHY transmit chain, placed
// between the MAC-data source and the FEC encoder. Each accepted beat of
// DATA_W bits is XORed with the 1+x^14+x^15 LFSR sequence (generalised by
// LFSR_W/TAPS), most significant bit first in time. The LFSR reloads from the
// stored seed automatically at every BLOCK_BITS boundary, and a bypass input
// lets a beat through unscrambled while still advancing the sequence.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   load       seed-load strobe (captures seed, restarts the block)
//   seed       seed value; seed[LFSR_W-1] is stage 1, seed[0] is stage LFSR_W
//   bypass     pass in_data through unscrambled for this accepted beat
//   in_valid   input beat valid
//   in_data    input bits, MSB first in time
//   in_ready   block can accept a beat this cycle
//   out_valid  output beat valid
//   out_data   scrambled bits, MSB first in time
//   out_last   this output beat closes a BLOCK_BITS block
//   out_ready  downstream accepts the output beat
//
// Handshake: a beat transfers on a side in any cycle where valid and ready are
// both high at the rising clock edge. The producer keeps valid and data
// stable until that transfer; in particular out_data/out_last do not change
// while out_valid=1 and out_ready=0. in_ready does not depend on in_valid.
// -----------------------------------------------------------------------------
module prbs_randomizer_par #(
   parameter int                DATA_W     = 8,
   parameter int                LFSR_W     = 15,
   parameter logic [LFSR_W-1:0] TAPS       = 15'h6000,
   parameter int                BLOCK_BITS = 96
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              bypass,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int CNT_W = $clog2(BLOCK_BITS) + 1;

   localparam logic [CNT_W-1:0] STEP_CNT  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_BITS);

   // --------------------------------------------------------------------------
   // Configuration checks, evaluated at elaboration.
   // --------------------------------------------------------------------------
   generate
      if (BLOCK_BITS % DATA_W != 0) begin : g_block_not_multiple
         $error("prbs_randomizer_par: BLOCK_BITS (%0d) is not a multiple of DATA_W (%0d)",
                BLOCK_BITS, DATA_W);
      end
      if (DATA_W < 1 || DATA_W > 16) begin : g_data_w_range
         $error("prbs_randomizer_par: DATA_W (%0d) outside 1..16", DATA_W);
      end
      if (LFSR_W < 2) begin : g_lfsr_w_range
         $error("prbs_randomizer_par: LFSR_W (%0d) must be at least 2", LFSR_W);
      end
   endgenerate

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [LFSR_W-1:0] lfsr;       // lfsr[LFSR_W-k] holds stage k
   logic [LFSR_W-1:0] seed_reg;   // seed used for automatic block reseed
   logic [CNT_W-1:0]  bit_cnt;    // bits consumed in the current block
   logic              seeded;     // at least one load since reset

   // --------------------------------------------------------------------------
   // Feedback: XOR of the stages selected by TAPS. TAPS bit k-1 selects
   // stage k, which lives at lfsr index LFSR_W-k.
   // --------------------------------------------------------------------------
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      logic f;
      f = 1'b0;
      for (int k = 1; k <= LFSR_W; k++) begin
         if (TAPS[k-1]) begin
            f = f ^ s[LFSR_W-k];
         end
      end
      return f;
   endfunction

   // --------------------------------------------------------------------------
   // Handshake
   // --------------------------------------------------------------------------
   logic accept;

   // Load owns the cycle: a beat presented alongside a load is refused so the
   // new seed and the cleared counter apply cleanly to the next beat.
   assign in_ready = !reset && seeded && !load && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // --------------------------------------------------------------------------
   // Unrolled scramble: DATA_W LFSR steps per beat. The MSB of the beat is the
   // earliest bit in time, so it consumes the first step.
   // --------------------------------------------------------------------------
   logic [LFSR_W-1:0] step_state;
   logic [DATA_W-1:0] scr_data;
   logic              step_fb;

   always_comb begin
      step_state = lfsr;
      scr_data   = '0;
      step_fb    = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         step_fb     = lfsr_fb(step_state);
         scr_data[i] = in_data[i] ^ step_fb;
         // New stage 1 takes the feedback; every other stage shifts down.
         step_state  = {step_fb, step_state[LFSR_W-1:1]};
      end
   end

   // --------------------------------------------------------------------------
   // Block boundary detection
   // --------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_next;
   logic             block_end;

   assign cnt_next  = bit_cnt + STEP_CNT;
   assign block_end = (cnt_next == BLOCK_CNT);

   // --------------------------------------------------------------------------
   // Seed, LFSR and counter
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr     <= '0;
         seed_reg <= '0;
         bit_cnt  <= '0;
         seeded   <= 1'b0;
      end else if (load) begin
         // Load beats a pending block end: the new seed starts a fresh block.
         lfsr     <= seed;
         seed_reg <= seed;
         bit_cnt  <= '0;
         seeded   <= 1'b1;
      end else if (accept) begin
         if (block_end) begin
            // Next block restarts the sequence from the stored seed.
            lfsr    <= seed_reg;
            bit_cnt <= '0;
         end else begin
            // Bypassed beats still advance, keeping block alignment intact.
            lfsr    <= step_state;
            bit_cnt <= cnt_next;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output register. Independent of load so a held beat survives a reload.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= bypass ? in_data : scr_data;
         out_last  <= block_end;
      end else if (out_ready) begin
         // Beat drained with nothing new behind it; data left as-is.
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule
